stopwatch_counter: RTL



---
 rtl/stopwatch_pkg.sv | 34 +++
 rtl/bcd_pair_counter.sv | 73 +++++++
 rtl/stopwatch_counter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared definitions for the stopwatch counter slice: the run/stop/clear
// state encoding, the default digit-pair limits and the BCD digit width.
// No ports; imported by bcd_pair_counter and stopwatch_counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam int CES_MAX_DEFAULT = 99;
  localparam int SEC_MAX_DEFAULT = 59;
  localparam int MIN_MAX_DEFAULT = 59;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  // Next state for a start_stop press: IDLE and STOP both start running,
  // RUN pauses.
  function automatic state_e next_on_start_stop(input state_e s);
    state_e n;
    case (s)
      ST_IDLE: n = ST_RUN;
      ST_RUN:  n = ST_STOP;
      ST_STOP: n = ST_RUN;
      default: n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// bcd_pair_counter
// Two-digit BCD counter (tens/units) that rolls over to 00 after MAX.
// Parameters:
//   MAX    - last value before rollover (e.g. 59 or 99)
// Ports:
//   clk    - system clock
//   res    - asynchronous active-high reset, clears both digits
//   inc    - advance the pair by one this cycle
//   clr    - synchronous clear to 00 (wins over inc)
//   tens   - registered tens digit
//   units  - registered units digit
//   carry  - combinational: inc while the pair sits at MAX, i.e. the pair
//            rolls this cycle; chains into the next pair's inc so the
//            whole carry ripple settles within one clock
module bcd_pair_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 99
) (
  input  logic clk,
  input  logic res,
  input  logic inc,
  input  logic clr,
  output bcd_t tens,
  output bcd_t units,
  output logic carry
);

  localparam bcd_t TENS_MAX  = BCD_W'(MAX / 10);
  localparam bcd_t UNITS_MAX = BCD_W'(MAX % 10);

  bcd_t tens_q, tens_d;
  bcd_t units_q, units_d;
  logic at_max;

  assign at_max = (tens_q == TENS_MAX) && (units_q == UNITS_MAX);
  assign carry  = inc && at_max && !clr;

  // Units roll 9->0 with a bump into tens; the whole pair returns to 00
  // once it reaches MAX, so tens can never pass its limit.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc) begin
      if (at_max) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == BCD_W'(9)) begin
        units_d = '0;
        tens_d  = tens_q + BCD_W'(1);
      end else begin
        units_d = units_q + BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
// Stopwatch core: counts 100 Hz tick pulses into MM:SS.CC BCD digits and
// runs an IDLE/RUN/STOP state machine from debounced button pulses. The
// digits feed the display SPI driver, which latches them on `update`.
// Optional feature macro: STOPWATCH_LAP_EN (lap freeze of the display).
// Parameters:
//   CES_MAX / SEC_MAX / MIN_MAX - last value of each digit pair
// Ports:
//   clk, res         - clock, asynchronous active-high reset
//   tick             - 100 Hz enable, one clk wide
//   start_stop       - button pulse: IDLE->RUN, RUN->STOP, STOP->RUN
//   clear            - button pulse: back to IDLE with zeroed digits
//   lap              - button pulse: freeze/unfreeze display (lap build)
//   min_X0..ces_0X   - presented BCD digits
//   running          - high while in RUN
//   update           - one-cycle strobe, presented digits changed
//   wrap             - one-cycle strobe on rollover past the last minute
//   lap_active       - high while the display is frozen
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CES_MAX = CES_MAX_DEFAULT,
  parameter int SEC_MAX = SEC_MAX_DEFAULT,
  parameter int MIN_MAX = MIN_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       res,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [2:0] min_X0,
  output logic [3:0] min_0X,
  output logic [2:0] sec_X0,
  output logic [3:0] sec_0X,
  output logic [3:0] ces_X0,
  output logic [3:0] ces_0X,
  output logic       running,
  output logic       update,
  output logic       wrap,
  output logic       lap_active
);

  state_e state_q, state_d;
  logic   running_q, running_d;
  logic   update_q, update_d;
  logic   wrap_q, wrap_d;
  logic   frozen_q, frozen_d;
  logic   unfreeze;
  logic   count_en;

  bcd_t ces_t, ces_u, sec_t, sec_u, min_t, min_u;
  logic ces_carry, sec_carry, min_carry;

  bcd_t ces_t_disp, ces_u_disp, sec_t_disp, sec_u_disp, min_t_disp, min_u_disp;

  // clear outranks everything, so a tick arriving alongside it is dropped.
  assign count_en = (state_q == ST_RUN) && tick && !clear;

  bcd_pair_counter #(.MAX(CES_MAX)) u_ces (
    .clk   (clk),
    .res   (res),
    .inc   (count_en),
    .clr   (clear),
    .tens  (ces_t),
    .units (ces_u),
    .carry (ces_carry)
  );

  bcd_pair_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .res   (res),
    .inc   (ces_carry),
    .clr   (clear),
    .tens  (sec_t),
    .units (sec_u),
    .carry (sec_carry)
  );

  bcd_pair_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .res   (res),
    .inc   (sec_carry),
    .clr   (clear),
    .tens  (min_t),
    .units (min_u),
    .carry (min_carry)
  );

`ifdef STOPWATCH_LAP_EN
  // Captured digits shown while frozen; the live counters keep running.
  bcd_t cap_ces_t_q, cap_ces_u_q, cap_sec_t_q, cap_sec_u_q, cap_min_t_q, cap_min_u_q;
  bcd_t cap_ces_t_d, cap_ces_u_d, cap_sec_t_d, cap_sec_u_d, cap_min_t_d, cap_min_u_d;
  logic lap_toggle;
  logic capture;

  // lap only acts in RUN; stopping while frozen leaves the freeze in place
  // until clear or a later lap press back in RUN.
  always_comb begin
    lap_toggle  = lap && (state_q == ST_RUN) && !clear;
    capture     = lap_toggle && !frozen_q;
    unfreeze    = lap_toggle && frozen_q;
    frozen_d    = frozen_q;
    if (clear) begin
      frozen_d = 1'b0;
    end else if (lap_toggle) begin
      frozen_d = !frozen_q;
    end
    cap_ces_t_d = cap_ces_t_q;
    cap_ces_u_d = cap_ces_u_q;
    cap_sec_t_d = cap_sec_t_q;
    cap_sec_u_d = cap_sec_u_q;
    cap_min_t_d = cap_min_t_q;
    cap_min_u_d = cap_min_u_q;
    // Capture the digits currently on display, so freezing never changes
    // what the driver sees.
    if (capture) begin
      cap_ces_t_d = ces_t;
      cap_ces_u_d = ces_u;
      cap_sec_t_d = sec_t;
      cap_sec_u_d = sec_u;
      cap_min_t_d = min_t;
      cap_min_u_d = min_u;
    end
  end

  assign ces_t_disp = frozen_q ? cap_ces_t_q : ces_t;
  assign ces_u_disp = frozen_q ? cap_ces_u_q : ces_u;
  assign sec_t_disp = frozen_q ? cap_sec_t_q : sec_t;
  assign sec_u_disp = frozen_q ? cap_sec_u_q : sec_u;
  assign min_t_disp = frozen_q ? cap_min_t_q : min_t;
  assign min_u_disp = frozen_q ? cap_min_u_q : min_u;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign frozen_d   = 1'b0;
  assign unfreeze   = 1'b0;

  assign ces_t_disp = ces_t;
  assign ces_u_disp = ces_u;
  assign sec_t_disp = sec_t;
  assign sec_u_disp = sec_u;
  assign min_t_disp = min_t;
  assign min_u_disp = min_u;
`endif

  // Next-state and strobe logic. update fires on a visible count, on clear
  // and on unfreeze; a count while frozen changes nothing on the display.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (start_stop) begin
      state_d = next_on_start_stop(state_q);
    end
    running_d = (state_d == ST_RUN);
    wrap_d    = min_carry;
    update_d  = clear || (count_en && !frozen_d) || unfreeze;
  end

  // Single state register with registered status outputs.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      update_q  <= 1'b0;
      wrap_q    <= 1'b0;
      frozen_q  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      cap_ces_t_q <= '0;
      cap_ces_u_q <= '0;
      cap_sec_t_q <= '0;
      cap_sec_u_q <= '0;
      cap_min_t_q <= '0;
      cap_min_u_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      update_q  <= update_d;
      wrap_q    <= wrap_d;
      frozen_q  <= frozen_d;
`ifdef STOPWATCH_LAP_EN
      cap_ces_t_q <= cap_ces_t_d;
      cap_ces_u_q <= cap_ces_u_d;
      cap_sec_t_q <= cap_sec_t_d;
      cap_sec_u_q <= cap_sec_u_d;
      cap_min_t_q <= cap_min_t_d;
      cap_min_u_q <= cap_min_u_d;
`endif
    end
  end

  // Minute and second tens never exceed 5, so only three bits leave.
  logic unused_tens_msb;
  assign unused_tens_msb = min_t_disp[3] | sec_t_disp[3];

  assign min_X0     = min_t_disp[2:0];
  assign min_0X     = min_u_disp;
  assign sec_X0     = sec_t_disp[2:0];
  assign sec_0X     = sec_u_disp;
  assign ces_X0     = ces_t_disp;
  assign ces_0X     = ces_u_disp;
  assign running    = running_q;
  assign update     = update_q;
  assign wrap       = wrap_q;
  assign lap_active = frozen_q;

endmodule
